mul32_seq: RTL and testbench

MUL32_SEQ -- requirements
Module: mul32_seq

---
 rtl/mul32_seq.sv | 154 +++++++++++++++
 tb/tb_mul32_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mul32_seq.sv
// mul32_seq: 32x32 -> 64 shift-add multiplier, signed or unsigned, with a block-CLA adder.
// Latency: out_valid is up in the 34th cycle after the accept cycle (32 CALC + 1 FIX + DONE).
// Backpressure: in_ready only in IDLE; DONE holds prod/out_valid until out_ready.
module bcla32_tree (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    function automatic logic [1:0] gp4(input logic [3:0] g, input logic [3:0] p);
        logic [1:0] r;
        r[1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r[0] = &p;
        return r;
    endfunction

    always_comb begin : cla
        logic [31:0] g, p, c;
        logic [7:0]  bg, bp, bc;
        logic [1:0]  gg, gp, gc;
        logic [1:0]  t;
        g = a & b;
        p = a ^ b;
        // Level 1: 4-bit blocks; level 2: two 16-bit groups of four blocks.
        for (int k = 0; k < 8; k++) begin
            t     = gp4(g[4*k +: 4], p[4*k +: 4]);
            bg[k] = t[1];
            bp[k] = t[0];
        end
        for (int j = 0; j < 2; j++) begin
            t     = gp4(bg[4*j +: 4], bp[4*j +: 4]);
            gg[j] = t[1];
            gp[j] = t[0];
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        cout  = gg[1] | (gp[1] & gc[1]);
        for (int j = 0; j < 2; j++) begin
            bc[4*j] = gc[j];
            for (int i = 0; i < 3; i++)
                bc[4*j+i+1] = bg[4*j+i] | (bp[4*j+i] & bc[4*j+i]);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k] = bc[k];
            for (int i = 0; i < 3; i++)
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
        end
        sum = p ^ c;
    end
endmodule

module mul32_seq #(
    parameter int SIGNED_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] prod
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [63:0] prod_q, prod_d;

    logic        sgn_mode;
    logic [31:0] add_b, add_s;
    logic        add_c;

    assign sgn_mode = (SIGNED_EN != 0) && is_signed;
    assign add_b    = lo_q[0] ? mcand_q : 32'd0;
    assign prod     = prod_q;

    bcla32_tree u_add (
        .a    (hi_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_s),
        .cout (add_c)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        prod_d    = prod_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
                    mcand_d = (sgn_mode && a[31]) ? (~a + 32'd1) : a;
                    lo_d    = (sgn_mode && b[31]) ? (~b + 32'd1) : b;
                    hi_d    = 32'd0;
                    cnt_d   = 6'd0;
                    neg_d   = sgn_mode && (a[31] ^ b[31]);
                    state_d = CALC;
                end
            end
            CALC: begin
                {hi_d, lo_d} = {add_c, add_s, lo_q[31:1]};
                cnt_d        = cnt_q + 6'd1;
                if (cnt_q == 6'd31)
                    state_d = FIX;
            end
            FIX: begin
                prod_d  = neg_q ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= 6'd0;
            neg_q   <= 1'b0;
            prod_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
        end
    end
endmodule

// File: tb/tb_mul32_seq.sv
// Bench for mul32_seq: directed corner cases plus random traffic, scoreboarded against a
// 64-bit reference product; a second instance with SIGNED_EN=0 shares all inputs.
module tb_mul32_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        is_signed = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, in_ready_u, out_valid_u;
    logic [63:0] prod, prod_u;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] expu_q[$];

    always #5 clk = ~clk;

    mul32_seq #(.SIGNED_EN(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready), .prod(prod)
    );

    mul32_seq #(.SIGNED_EN(0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .a(a), .b(b), .is_signed(is_signed),
        .out_valid(out_valid_u), .out_ready(out_ready), .prod(prod_u)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        logic signed [63:0] sx, sy;
        if (s) begin
            sx = $signed({{32{x[31]}}, x});
            sy = $signed({{32{y[31]}}, y});
            return sx * sy;
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Scoreboard: sampled mid-cycle so that handshakes seen here complete on the next edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            expu_q.delete();
        end else begin
            if (out_valid)
                chk("valid_has_pending_op", 64'(exp_q.size() != 0), 64'd1);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                chk("sb_prod", prod, exp_q.pop_front());
                chk("sb_valid_u", 64'(out_valid_u), 64'd1);
                if (expu_q.size() != 0)
                    chk("sb_prod_u", prod_u, expu_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_mul(a, b, is_signed));
                expu_q.push_back(ref_mul(a, b, 1'b0));
            end
        end
    end

    task automatic accept_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                             input int pre_idle);
        logic hs;
        int   n;
        repeat (pre_idle) begin @(posedge clk); #1; end
        in_valid = 1'b1; a = ta; b = tb_; is_signed = ts;
        n = 0;
        do begin
            hs = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!hs && n < 200);
        chk("accept_timeout", 64'(hs), 64'd1);
        // Operands change after accept; the DUT must keep the sampled values.
        in_valid = 1'b0; a = $urandom; b = $urandom; is_signed = ($urandom_range(0, 1) != 0);
    endtask

    // Returns the cycle index (accept cycle = 0) in which out_valid is first seen high.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic consume(input int pct);
        logic hs;
        int   n;
        n = 0;
        do begin
            out_ready = ($urandom_range(0, 99) < pct);
            hs = out_valid && out_ready;
            @(posedge clk); #1;
            n++;
        end while (!hs && n < 400);
        out_ready = 1'b0;
        chk("consume_timeout", 64'(hs), 64'd1);
    endtask

    task automatic directed(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                            input logic ts, input logic [63:0] want, input logic [63:0] want_u);
        int cyc;
        accept_op(ta, tb_, ts, 0);
        wait_valid(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'd34);
        chk({tag, "_prod"}, prod, want);
        chk({tag, "_prod_u"}, prod_u, want_u);
        consume(100);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_prod", prod, 64'd0);
        chk("rst_prod_u", prod_u, 64'd0);

        // Max unsigned operands, then a 10-cycle stall in DONE.
        accept_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        wait_valid(cyc);
        chk("ff_latency", 64'(cyc), 64'd34);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_prod", prod, 64'hFFFF_FFFE_0000_0001);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_prod_held", prod, 64'hFFFF_FFFE_0000_0001);

        directed("neg3x5", 32'hFFFF_FFFD, 32'd5, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0004_FFFF_FFF1);
        directed("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                 64'h0000_0000_0000_0001, 64'hFFFF_FFFE_0000_0001);
        directed("min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1,
                 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
        directed("neg_x_pos", 32'h8000_0000, 32'd1, 1'b1,
                 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000);
        directed("zero", 32'd0, 32'hDEAD_BEEF, 1'b1, 64'd0, 64'd0);

        // Reset while CALC has cnt == 15 aborts the operation.
        accept_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0);
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_prod", prod, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            chk("abort_no_output", 64'(out_valid | out_valid_u), 64'd0);
        end
        directed("7x6", 32'd7, 32'd6, 1'b0, 64'd42, 64'd42);

        for (int i = 0; i < 1000; i++) begin
            accept_op($urandom, $urandom, ($urandom_range(0, 1) != 0), $urandom_range(0, 3));
            consume($urandom_range(30, 100));
        end
        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
